cosim_reset_sequencer: RTL
==========================

Name: cosim_reset_sequencer

Overview:
Synthesizable, parametrised successor to the testbench clock/reset generator used in the t1rocketemu cosim harness. It runs from one free-running clock and does the following:
- sequences staggered per-domain reset release and an init window;
- runs a commit-interval watchdog;
- gates end-of-simulation on all domains reporting idle.

It sits between the cosim control logic (the watchdog DPI status is decoded to done_req/error_req) and the DUT reset domains. It adds what the original lacks: multiple domains, soft reset, a drain timeout and fault codes.

Parameters:
- NUM_DOMAINS, 2, number of independent reset domains (1..8).
- RESET_CYCLES, 5, cycles before domain 0 reset releases (>=1).
- INIT_CYCLES, 1, cycles init_flag stays high (1..RESET_CYCLES).
- STAGGER, 2, extra cycles between successive domain releases (>=0).
- TIMEOUT_W, 32, watchdog counter / limit width.
- DRAIN_LIMIT, 1000, max cycles in DRAIN waiting for idle.

Ports:
- clock, input, 1, single clock.
- reset, input, 1, asynchronous, active-low hard reset.
- commit, input, 1, instruction-commit pulse; kicks the watchdog.
- done_req, input, 1, pulse: stimulus finished (DPI status 255).
- error_req, input, 1, pulse: external error (DPI status not 0 and not 255).
- soft_reset_req, input, 1, pulse: restart the sequence without hard reset.
- idle, input, NUM_DOMAINS, per-domain idle.
- timeout_limit, input, TIMEOUT_W, max cycles between commits; 0 disables.
- domain_reset, output, NUM_DOMAINS, active-high reset per domain.
- init_flag, output, 1, high during the init window.
- running, output, 1, high in RUN or DRAIN.
- finish, output, 1, sticky clean completion.
- fatal, output, 1, sticky error.
- fault_code, output, 2, 00 none / 01 watchdog / 10 drain timeout / 11 external.
- cycle_count, output, 64, cycles since hard reset.

Behaviour:
- Hard reset (reset=0) forces, asynchronously:
  - domain_reset all 1s, init_flag=1;
  - running, finish, fatal = 0; fault_code=00; cycle_count=0;
  - state HOLD, phase counter, watchdog counter and drain counter = 0.
- Edge numbering: edge k is the k-th rising clock edge after reset deassertion (k=1 first).
- States: HOLD, RUN, DRAIN, DONE, FAULT. All outputs are registered.
- HOLD behaviour:
  - the phase counter increments each edge;
  - init_flag falls at edge INIT_CYCLES;
  - domain_reset[i] falls at edge RESET_CYCLES + i*STAGGER;
  - at edge RESET_CYCLES + (NUM_DOMAINS-1)*STAGGER, enter RUN and set running=1 on that same edge.
- Watchdog (RUN and DRAIN only):
  - the counter clears on commit, otherwise increments and saturates at all-ones;
  - it clears on entry to RUN;
  - if timeout_limit != 0 and the counter reaches timeout_limit, go to FAULT with code 01.
- RUN: on done_req, go to DRAIN and clear the drain counter.
- DRAIN:
  - if all idle bits are 1, go to DONE and set finish=1;
  - else increment the drain counter; when it reaches DRAIN_LIMIT, go to FAULT with code 10;
  - done_req and all-idle on the same edge in RUN: DRAIN on that edge, DONE one edge later (minimum latency 1).
- error_req in RUN or DRAIN: go to FAULT with code 11.
- FAULT:
  - fatal=1, running=0;
  - domain_reset is left as is (do not disturb DUT state for debug);
  - fault_code holds the first fault; later faults are ignored.
- DONE: running=0 and finish=1, held. done_req and error_req are ignored in DONE and FAULT.
- soft_reset_req, honoured in any state except FAULT:
  - next edge: state HOLD, phase counter 0;
  - domain_reset all 1s, init_flag=1, finish=0, running=0;
  - the sequence then restarts with the edge numbering relative to that edge;
  - cycle_count is not cleared.
- Priority on the same edge: soft_reset_req > error_req > watchdog timeout > drain timeout > done/idle.
- cycle_count:
  - increments every edge in every state and saturates at 2^64-1;
  - cleared only by hard reset.
- Hard reset mid-operation: immediate return to reset values, including clearing the sticky fatal, finish and fault_code.

Decomposition:
- Package cosim_ctrl_pkg: state_e enum (HOLD, RUN, DRAIN, DONE, FAULT), fault_e enum (FAULT_NONE, FAULT_WDOG, FAULT_DRAIN, FAULT_EXT), localparam FAULT_W=2.
- One sub-module, cosim_watchdog_counter. It is a TIMEOUT_W-bit saturating counter with:
  - inputs: enable, clear (kick), limit;
  - output: expired (limit != 0 and count == limit).

Test Plan:
- Defaults, hard reset released, no further stimulus:
  - init_flag falls at edge 1;
  - domain_reset[0] falls at edge 5 and domain_reset[1] at edge 7;
  - running=1 at edge 7;
  - cycle_count=7 after edge 7.
- timeout_limit=10, no commits after RUN entry: fault at edge 17 of the run; fatal=1, fault_code=01, running=0, domain_reset stays 00.
- Pulse done_req with idle=2'b01, raise idle to 11 three cycles later: finish=1 one edge after idle=11; a subsequent error_req leaves fatal=0.
- DRAIN_LIMIT=4, done_req with idle held at 00: FAULT with code 10 four edges after DRAIN entry.
- soft_reset_req and error_req on the same edge during RUN:
  - soft reset wins, fatal stays 0;
  - domain_reset=11 next edge and the release sequence repeats (edges 5 and 7 relative);
  - cycle_count keeps counting.
- Hard reset asserted mid-DRAIN: all outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/cosim_ctrl_pkg.sv
// Shared types for the cosim reset/control block.
//   state_e : sequencer states (HOLD, RUN, DRAIN, DONE, FAULT)
//   fault_e : fault codes reported on fault_code (first fault wins)
//   FAULT_W : width of the fault code
package cosim_ctrl_pkg;

  localparam int FAULT_W = 2;

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    DRAIN,
    DONE,
    FAULT
  } state_e;

  typedef enum logic [FAULT_W-1:0] {
    FAULT_NONE  = 2'b00,
    FAULT_WDOG  = 2'b01,
    FAULT_DRAIN = 2'b10,
    FAULT_EXT   = 2'b11
  } fault_e;

endpackage

// File: rtl/cosim_watchdog_counter.sv
// Saturating commit-interval counter.
//   clock, reset : clock and asynchronous active-low reset
//   enable       : count this cycle
//   clear        : kick; forces the count back to zero (wins over enable)
//   limit        : expiry threshold, 0 disables expiry
//   expired      : the count reaches limit on the coming edge
module cosim_watchdog_counter #(
  parameter int unsigned TIMEOUT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  localparam logic [TIMEOUT_W-1:0] ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] count;
  logic [TIMEOUT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (enable && !(&count)) begin
      count_nxt = count + ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  // Expiry is judged on the value this edge produces, so the controller
  // leaves RUN on the very edge the count reaches the limit.
  assign expired = (limit != '0) && (count_nxt == limit);

endmodule

// File: rtl/cosim_reset_sequencer.sv
// Cosim clock/reset sequencer: staggered per-domain reset release with an
// init window, commit watchdog, drain-until-idle end of simulation.
//   clock, reset   : free-running clock, asynchronous active-low hard reset
//   commit         : instruction-commit pulse, kicks the watchdog
//   done_req       : stimulus finished pulse
//   error_req      : external error pulse
//   soft_reset_req : restart the release sequence (ignored in FAULT)
//   idle           : per-domain idle
//   timeout_limit  : max cycles between commits, 0 disables
//   domain_reset   : active-high reset per domain
//   init_flag      : high during the init window
//   running        : high in RUN or DRAIN
//   finish/fatal   : sticky clean completion / sticky error
//   fault_code     : first fault seen (see cosim_ctrl_pkg::fault_e)
//   cycle_count    : saturating cycles since hard reset
module cosim_reset_sequencer
  import cosim_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS  = 2,
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned INIT_CYCLES  = 1,
  parameter int unsigned STAGGER      = 2,
  parameter int unsigned TIMEOUT_W    = 32,
  parameter int unsigned DRAIN_LIMIT  = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   commit,
  input  logic                   done_req,
  input  logic                   error_req,
  input  logic                   soft_reset_req,
  input  logic [NUM_DOMAINS-1:0] idle,
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   init_flag,
  output logic                   running,
  output logic                   finish,
  output logic                   fatal,
  output logic [FAULT_W-1:0]     fault_code,
  output logic [63:0]            cycle_count
);

  // Phase value at which the last domain leaves reset and RUN begins.
  localparam int unsigned LAST_EDGE = RESET_CYCLES + (NUM_DOMAINS - 1) * STAGGER;

  state_e      state;
  logic [31:0] phase;
  logic [31:0] phase_nxt;
  logic [31:0] drain_cnt;
  logic [31:0] drain_nxt;
  logic        wdog_active;
  logic        wdog_expired;

  function automatic logic [31:0] release_edge(input int unsigned d);
    return RESET_CYCLES + d * STAGGER;
  endfunction

  assign phase_nxt   = phase + 32'd1;
  assign drain_nxt   = drain_cnt + 32'd1;
  assign wdog_active = (state == RUN) || (state == DRAIN);

  // Held cleared outside RUN/DRAIN, which also gives the clear on RUN entry.
  cosim_watchdog_counter #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .enable  (wdog_active),
    .clear   (commit || !wdog_active),
    .limit   (timeout_limit),
    .expired (wdog_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= HOLD;
      phase        <= '0;
      drain_cnt    <= '0;
      domain_reset <= '1;
      init_flag    <= 1'b1;
      running      <= 1'b0;
      finish       <= 1'b0;
      fatal        <= 1'b0;
      fault_code   <= FAULT_NONE;
      cycle_count  <= '0;
    end else begin
      if (!(&cycle_count)) begin
        cycle_count <= cycle_count + 64'd1;
      end

      if (soft_reset_req && (state != FAULT)) begin
        state        <= HOLD;
        phase        <= '0;
        domain_reset <= '1;
        init_flag    <= 1'b1;
        finish       <= 1'b0;
        running      <= 1'b0;
      end else begin
        unique case (state)
          HOLD: begin
            phase     <= phase_nxt;
            init_flag <= (phase_nxt < INIT_CYCLES);
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
              domain_reset[i] <= (phase_nxt < release_edge(i));
            end
            if (phase_nxt == LAST_EDGE) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (error_req) begin
              state      <= FAULT;
              fatal      <= 1'b1;
              running    <= 1'b0;
              fault_code <= FAULT_EXT;
            end else if (wdog_expired) begin
              state      <= FAULT;
              fatal      <= 1'b1;
              running    <= 1'b0;
              fault_code <= FAULT_WDOG;
            end else if (done_req) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
          DRAIN: begin
            if (error_req) begin
              state      <= FAULT;
              fatal      <= 1'b1;
              running    <= 1'b0;
              fault_code <= FAULT_EXT;
            end else if (wdog_expired) begin
              state      <= FAULT;
              fatal      <= 1'b1;
              running    <= 1'b0;
              fault_code <= FAULT_WDOG;
            end else if (!(&idle) && (drain_nxt == DRAIN_LIMIT)) begin
              state      <= FAULT;
              fatal      <= 1'b1;
              running    <= 1'b0;
              fault_code <= FAULT_DRAIN;
            end else if (&idle) begin
              state   <= DONE;
              finish  <= 1'b1;
              running <= 1'b0;
            end else begin
              drain_cnt <= drain_nxt;
            end
          end
          // DONE and FAULT are terminal until a soft (DONE) or hard reset;
          // domain_reset is left untouched so DUT state survives for debug.
          DONE:  state <= DONE;
          FAULT: state <= FAULT;
          default: state <= FAULT;
        endcase
      end
    end
  end

endmodule
